// File: rtl/async_fifo_flags.sv
// Dual-clock FIFO with Gray-pointer synchronisers, occupancy counts and almost-full/empty flags.
// Optional sticky overflow/underflow flags are built when ASYNC_FIFO_ERR_FLAGS_EN is defined.
module async_fifo_flags #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = DEPTH - 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic                     wclk,
    input  logic                     w_rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   wr_count,
    input  logic                     rclk,
    input  logic                     r_rst_n,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   rd_count
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                     overflow,
    output logic                     underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW+1)'(AE_LEVEL);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [AW:0] wr_ptr_reg, wr_ptr_next, wr_gray_reg;
    logic [AW:0] rs_sync_reg [SYNC_STAGES];
    logic [AW:0] rs_gray;
    logic        wr_accept;

    // ---------------- read domain -----------------
    logic [AW:0]      rd_ptr_reg, rd_ptr_next, rd_gray_reg;
    logic [AW:0]      ws_sync_reg [SYNC_STAGES];
    logic [AW:0]      ws_gray;
    logic             rd_accept;
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;

    assign wr_accept   = wr_en && !full;
    assign wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, wr_accept};

    always_ff @(posedge wclk) begin
        if (!w_rst_n) begin
            wr_ptr_reg  <= '0;
            wr_gray_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            wr_gray_reg <= bin2gray(wr_ptr_next);
        end
    end

    always_ff @(posedge wclk) begin
        if (w_rst_n && wr_accept) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    // Only registered Gray pointers enter the opposite domain's synchroniser.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge wclk) begin
                    if (!w_rst_n) rs_sync_reg[gi] <= '0;
                    else          rs_sync_reg[gi] <= rd_gray_reg;
                end
                always_ff @(posedge rclk) begin
                    if (!r_rst_n) ws_sync_reg[gi] <= '0;
                    else          ws_sync_reg[gi] <= wr_gray_reg;
                end
            end else begin : g_next
                always_ff @(posedge wclk) begin
                    if (!w_rst_n) rs_sync_reg[gi] <= '0;
                    else          rs_sync_reg[gi] <= rs_sync_reg[gi-1];
                end
                always_ff @(posedge rclk) begin
                    if (!r_rst_n) ws_sync_reg[gi] <= '0;
                    else          ws_sync_reg[gi] <= ws_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rs_gray     = rs_sync_reg[SYNC_STAGES-1];
    assign ws_gray     = ws_sync_reg[SYNC_STAGES-1];

    // Full when the write pointer leads the read pointer by exactly one lap.
    assign full        = (wr_gray_reg == {~rs_gray[AW:AW-1], rs_gray[AW-2:0]});
    assign wr_count    = wr_ptr_reg - gray2bin(rs_gray);
    assign almost_full = (wr_count >= AF_LVL);

    assign rd_accept   = rd_en && !empty;
    assign rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, rd_accept};

    always_ff @(posedge rclk) begin
        if (!r_rst_n) begin
            rd_ptr_reg   <= '0;
            rd_gray_reg  <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            rd_gray_reg  <= bin2gray(rd_ptr_next);
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
            end
        end
    end

    assign empty        = (rd_gray_reg == ws_gray);
    assign rd_count     = gray2bin(ws_gray) - rd_ptr_reg;
    assign almost_empty = (rd_count <= AE_LVL);
    assign rd_data      = rd_data_reg;
    assign rd_valid     = rd_valid_reg;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic overflow_reg, underflow_reg;

    always_ff @(posedge wclk) begin
        if (!w_rst_n)          overflow_reg <= 1'b0;
        else if (wr_en && full) overflow_reg <= 1'b1;
    end

    always_ff @(posedge rclk) begin
        if (!r_rst_n)            underflow_reg <= 1'b0;
        else if (rd_en && empty) underflow_reg <= 1'b1;
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_async_fifo_flags.sv
// Scoreboard bench for async_fifo_flags: stimulus pushes expected words, a read-side monitor pops and compares.
`timescale 1ns/100ps
module tb_async_fifo_flags;

    logic       wclk = 1'b0, rclk = 1'b0;
    logic       w_rst_n, r_rst_n, wr_en, rd_en;
    logic [7:0] wr_data, rd_data;
    logic       full, almost_full, empty, almost_empty, rd_valid;
    logic [4:0] wr_count, rd_count;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    real wclk_half = 5.0;
    real rclk_half = 13.5;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    async_fifo_flags #(
        .WIDTH(8), .DEPTH(16), .SYNC_STAGES(2), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .wclk(wclk), .w_rst_n(w_rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .wr_count(wr_count),
        .rclk(rclk), .r_rst_n(r_rst_n), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
        .rd_count(rd_count)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    initial forever #(wclk_half) wclk = ~wclk;
    initial forever #(rclk_half) rclk = ~rclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every rd_valid word must match the oldest outstanding expectation.
    always @(negedge rclk) begin
        logic [7:0] e;
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_valid", {31'd0, rd_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", {24'd0, rd_data}, {24'd0, e});
                $display("read  0x%02h expected 0x%02h", rd_data, e);
            end
        end
    end

    task automatic reset_both();
        wr_en = 1'b0;
        rd_en = 1'b0;
        w_rst_n = 1'b0;
        r_rst_n = 1'b0;
        repeat (4) @(posedge rclk);
        repeat (4) @(posedge wclk);
        @(negedge wclk);
        w_rst_n = 1'b1;
        @(negedge rclk);
        r_rst_n = 1'b1;
        @(negedge rclk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_full"},         {31'd0, full},         32'd0);
        chk({tag, "_almost_full"},  {31'd0, almost_full},  32'd0);
        chk({tag, "_wr_count"},     {27'd0, wr_count},     32'd0);
        chk({tag, "_empty"},        {31'd0, empty},        32'd1);
        chk({tag, "_almost_empty"}, {31'd0, almost_empty}, 32'd1);
        chk({tag, "_rd_count"},     {27'd0, rd_count},     32'd0);
        chk({tag, "_rd_valid"},     {31'd0, rd_valid},     32'd0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk({tag, "_overflow"},     {31'd0, overflow},     32'd0);
        chk({tag, "_underflow"},    {31'd0, underflow},    32'd0);
`endif
    endtask

    task automatic wait_not_empty(input string name);
        int n = 0;
        while (empty && n < 10) begin
            @(negedge rclk);
            n++;
        end
        chk(name, {31'd0, empty}, 32'd0);
    endtask

    task automatic single_word(input logic [7:0] d);
        @(negedge wclk);
        wr_en = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        $display("write 0x%02h", d);
        @(negedge wclk);
        wr_en = 1'b0;
        wait_not_empty("single_not_empty");
        @(negedge rclk);
        rd_en = 1'b1;
        @(negedge rclk);
        rd_en = 1'b0;
        chk("single_rd_valid", {31'd0, rd_valid}, 32'd1);
    endtask

    task automatic run_traffic(input int n, input string tag);
        fork
            begin
                int k = 0;
                int cyc = 0;
                while (k < n && cyc < n * 6) begin
                    @(negedge wclk);
                    cyc++;
                    if (!full && (cyc % 4) != 3) begin
                        wr_en = 1'b1;
                        wr_data = 8'(k * 37 + 11);
                        exp_q.push_back(8'(k * 37 + 11));
                        k++;
                    end else begin
                        wr_en = 1'b0;
                    end
                end
                @(negedge wclk);
                wr_en = 1'b0;
                chk({tag, "_words_written"}, k, n);
            end
            begin
                int r = 0;
                int cyc = 0;
                while (r < n && cyc < n * 6) begin
                    @(negedge rclk);
                    cyc++;
                    if (!empty && (cyc % 5) != 2) begin
                        rd_en = 1'b1;
                        r++;
                    end else begin
                        rd_en = 1'b0;
                    end
                end
                @(negedge rclk);
                rd_en = 1'b0;
                chk({tag, "_words_read"}, r, n);
            end
        join
        repeat (3) @(negedge rclk);
        chk({tag, "_scoreboard_drained"}, exp_q.size(), 0);
        chk({tag, "_empty_after"}, {31'd0, empty}, 32'd1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk({tag, "_no_overflow"},  {31'd0, overflow},  32'd0);
        chk({tag, "_no_underflow"}, {31'd0, underflow}, 32'd0);
`endif
    endtask

    initial begin
        int n;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wr_data = 8'h00;
        w_rst_n = 1'b0;
        r_rst_n = 1'b0;
        reset_both();
        check_idle("reset");

        // Fill 0x00..0x0F with no reads; 17th write must be ignored.
        @(negedge wclk);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = i[7:0];
            exp_q.push_back(i[7:0]);
            @(negedge wclk);
            $display("write 0x%02h wr_count=%0d full=%0b", i[7:0], wr_count, full);
            chk("fill_wr_count",    {27'd0, wr_count},    i + 1);
            chk("fill_almost_full", {31'd0, almost_full}, (i + 1 >= 14) ? 32'd1 : 32'd0);
            chk("fill_full",        {31'd0, full},        (i + 1 == 16) ? 32'd1 : 32'd0);
        end
        wr_data = 8'hAA;
        @(negedge wclk);
        wr_en = 1'b0;
        chk("overfill_wr_count", {27'd0, wr_count}, 32'd16);
        chk("overfill_full",     {31'd0, full},     32'd1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("overflow_set", {31'd0, overflow}, 32'd1);
`endif

        n = 0;
        while (rd_count != 5'd16 && n < 10) begin
            @(negedge rclk);
            n++;
        end
        @(negedge rclk);
        chk("full_rd_count",     {27'd0, rd_count},     32'd16);
        chk("full_almost_empty", {31'd0, almost_empty}, 32'd0);
        chk("full_empty",        {31'd0, empty},        32'd0);

        // Drain all 16; the monitor checks data order.
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            @(negedge rclk);
            chk("drain_rd_valid",     {31'd0, rd_valid},     32'd1);
            chk("drain_rd_count",     {27'd0, rd_count},     15 - i);
            chk("drain_empty",        {31'd0, empty},        (i == 15) ? 32'd1 : 32'd0);
            chk("drain_almost_empty", {31'd0, almost_empty}, (15 - i <= 2) ? 32'd1 : 32'd0);
        end
        @(negedge rclk);
        rd_en = 1'b0;
        chk("underread_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("underread_empty",    {31'd0, empty},    32'd1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("underflow_set", {31'd0, underflow}, 32'd1);
`endif

        n = 0;
        while (wr_count != 5'd0 && n < 20) begin
            @(negedge wclk);
            n++;
        end
        chk("drained_wr_count", {27'd0, wr_count}, 32'd0);
        chk("drained_full",     {31'd0, full},     32'd0);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        chk("overflow_sticky",  {31'd0, overflow}, 32'd1);
        chk("underflow_sticky", {31'd0, underflow}, 32'd1);
`endif

        // Single write into empty FIFO: empty must clear within 3 rclk edges.
        @(negedge wclk);
        wr_en = 1'b1;
        wr_data = 8'h5A;
        exp_q.push_back(8'h5A);
        @(posedge wclk);
        #1;
        wr_en = 1'b0;
        n = 0;
        while (empty && n < 3) begin
            @(posedge rclk);
            #1;
            n++;
        end
        chk("empty_clear_within_3", {31'd0, empty}, 32'd0);
        @(negedge rclk);
        rd_en = 1'b1;
        @(negedge rclk);
        rd_en = 1'b0;
        chk("read_5a_valid", {31'd0, rd_valid}, 32'd1);

        // Fill 10 words, then a joint reset must discard them.
        @(negedge wclk);
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'h40 + i);
            @(negedge wclk);
        end
        wr_en = 1'b0;
        w_rst_n = 1'b0;
        r_rst_n = 1'b0;
        repeat (4) @(posedge rclk);
        @(negedge wclk);
        w_rst_n = 1'b1;
        @(negedge rclk);
        r_rst_n = 1'b1;
        @(negedge rclk);
        check_idle("midreset");
        single_word(8'h33);

        run_traffic(2000, "run_w_fast");
        wclk_half = 13.5;
        rclk_half = 5.0;
        reset_both();
        check_idle("swap_reset");
        run_traffic(2000, "run_r_fast");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(3_000_000);
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
